// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the two requester handshakes, the shared response bus and the
//   ALU operand/result wires of alu_arbiter.
//   slave  : arbiter side (takes requests and alu_res, drives ready/resp/alu_*)
//   master : requester + ALU side (drives requests and alu_res)
interface alu_arbiter_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int FUNCT_W = 4
);
   logic               req0_valid;
   logic               req0_ready;
   logic [WIDTH-1:0]   req0_a;
   logic [WIDTH-1:0]   req0_b;
   logic [SHAMT_W-1:0] req0_shamt;
   logic [FUNCT_W-1:0] req0_funct;

   logic               req1_valid;
   logic               req1_ready;
   logic [WIDTH-1:0]   req1_a;
   logic [WIDTH-1:0]   req1_b;
   logic [SHAMT_W-1:0] req1_shamt;
   logic [FUNCT_W-1:0] req1_funct;

   logic               resp0_valid;
   logic               resp1_valid;
   logic [WIDTH-1:0]   resp_data;
   logic               resp_err;

   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic [SHAMT_W-1:0] alu_shamt;
   logic [FUNCT_W-1:0] alu_funct;
   logic [WIDTH-1:0]   alu_res;

   logic               busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_shamt, req0_funct,
      input  req1_valid, req1_a, req1_b, req1_shamt, req1_funct,
      output req0_ready, req1_ready,
      output resp0_valid, resp1_valid, resp_data, resp_err,
      output alu_a, alu_b, alu_shamt, alu_funct,
      input  alu_res,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_shamt, req0_funct,
      output req1_valid, req1_a, req1_b, req1_shamt, req1_funct,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp1_valid, resp_data, resp_err,
      input  alu_a, alu_b, alu_shamt, alu_funct,
      output alu_res,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one registered (1-cycle latency) ALU between two requesters.
//   Round-robin grant, valid/ready request handshake, one-cycle response
//   pulse to the requester that issued the operation.
//   Ports:
//     clk  - clock, all state updates on posedge
//     rst  - synchronous active-high reset; forces every output to 0
//     bus  - alu_arbiter_if.slave: req0/req1 handshakes, resp0/resp1_valid,
//            resp_data, resp_err, alu_a/b/shamt/funct, alu_res, busy
//   Sequence: IDLE (accept) -> ISSUE (ALU samples) -> WAIT (alu_res valid,
//   captured) -> DONE (response pulse). Illegal funct skips straight to DONE.
module alu_arbiter #(
   parameter int WIDTH     = 32,
   parameter int SHAMT_W   = 5,
   parameter int FUNCT_W   = 4,
   parameter int MAX_FUNCT = 8
) (
   input logic         clk,
   input logic         rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               last_grant_q, last_grant_d;
   logic               owner_q, owner_d;
   logic               err_q, err_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [SHAMT_W-1:0] shamt_q, shamt_d;
   logic [FUNCT_W-1:0] funct_q, funct_d;
   logic [WIDTH-1:0]   data_q, data_d;

   logic               grant0, grant1;
   logic [FUNCT_W-1:0] sel_funct;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      err_d        = err_q;
      a_d          = a_q;
      b_d          = b_q;
      shamt_d      = shamt_q;
      funct_d      = funct_q;
      data_d       = data_q;
      grant0       = 1'b0;
      grant1       = 1'b0;
      sel_funct    = bus.req1_valid ? bus.req1_funct : bus.req0_funct;

      unique case (state_q)
         IDLE: begin
            // Contention goes to whoever did not win last time.
            if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
               grant0 = 1'b1;
            end else if (bus.req1_valid) begin
               grant1 = 1'b1;
            end
            sel_funct = grant1 ? bus.req1_funct : bus.req0_funct;
            if (grant0 || grant1) begin
               owner_d      = grant1;
               last_grant_d = grant1;
               a_d          = grant1 ? bus.req1_a     : bus.req0_a;
               b_d          = grant1 ? bus.req1_b     : bus.req0_b;
               shamt_d      = grant1 ? bus.req1_shamt : bus.req0_shamt;
               funct_d      = sel_funct;
               if (sel_funct > FUNCT_W'(MAX_FUNCT)) begin
                  // Illegal op never touches the ALU; respond next cycle with 0.
                  err_d   = 1'b1;
                  data_d  = '0;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            data_d  = bus.alu_res;
            state_d = DONE;
         end
         DONE: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         err_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         shamt_q      <= '0;
         funct_q      <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         err_q        <= err_d;
         a_q          <= a_d;
         b_q          <= b_d;
         shamt_q      <= shamt_d;
         funct_q      <= funct_d;
         data_q       <= data_d;
      end
   end

   // Every output is forced low while rst is asserted, even before the
   // reset edge has cleared the registers.
   assign bus.req0_ready  = !rst && grant0;
   assign bus.req1_ready  = !rst && grant1;
   assign bus.resp0_valid = !rst && (state_q == DONE) && !owner_q;
   assign bus.resp1_valid = !rst && (state_q == DONE) &&  owner_q;
   assign bus.resp_err    = !rst && (state_q == DONE) &&  err_q;
   assign bus.resp_data   = rst ? '0 : data_q;
   assign bus.alu_a       = rst ? '0 : a_q;
   assign bus.alu_b       = rst ? '0 : b_q;
   assign bus.alu_shamt   = rst ? '0 : shamt_q;
   assign bus.alu_funct   = rst ? '0 : funct_q;
   assign bus.busy        = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Contains a registered ALU stub
//   (ADD SUB AND OR XOR SLT SLL SRA SRL = 0..8; shift by shamt, or by b[4:0]
//   when shamt is 0) and walks the arbiter through reset, single ops,
//   contention, round-robin, illegal funct, SRA and mid-op reset.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32), .SHAMT_W(5), .FUNCT_W(4)) bus ();

   alu_arbiter #(.WIDTH(32), .SHAMT_W(5), .FUNCT_W(4), .MAX_FUNCT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] f, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
      logic [4:0] s;
      s = (sh != 5'd0) ? sh : b[4:0];
      case (f)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return {31'd0, $signed(a) < $signed(b)};
         4'd6:    return a << s;
         4'd7:    return $unsigned($signed(a) >>> s);
         4'd8:    return a >> s;
         default: return 32'd0;
      endcase
   endfunction

   initial bus.alu_res = '0;
   always @(posedge clk) bus.alu_res <= alu_f(bus.alu_funct, bus.alu_a, bus.alu_b, bus.alu_shamt);

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int r, input logic v, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      if (r == 0) begin
         bus.req0_valid = v; bus.req0_funct = f; bus.req0_a = a; bus.req0_b = b; bus.req0_shamt = sh;
      end else begin
         bus.req1_valid = v; bus.req1_funct = f; bus.req1_a = a; bus.req1_b = b; bus.req1_shamt = sh;
      end
   endtask

   function automatic logic rdy(input int r);
      return (r == 0) ? bus.req0_ready : bus.req1_ready;
   endfunction

   function automatic logic rsp(input int r);
      return (r == 0) ? bus.resp0_valid : bus.resp1_valid;
   endfunction

   // Issue one op on requester r, wait (bounded) for ready, then check that
   // the response arrives exactly 3 cycles (legal) or 1 cycle (illegal) later.
   task automatic do_op(input string tag, input int r, input logic [3:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_d, input logic exp_e);
      int wait_n;
      int lat;
      wait_n = 0;
      @(negedge clk);
      set_req(r, 1'b1, f, a, b, sh);
      #1;
      while (!rdy(r) && wait_n < 12) begin
         @(negedge clk); #1; wait_n++;
      end
      chk({tag, " ready"}, {31'd0, rdy(r)}, 32'd1);
      lat = exp_e ? 1 : 3;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == 1) set_req(r, 1'b0, 4'hF, 32'hDEADBEEF, 32'h12345678, 5'h1F);
         #1;
         if (k < lat) chk({tag, " quiet"}, {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
      end
      chk({tag, " resp_valid"}, {31'd0, rsp(r)}, 32'd1);
      chk({tag, " other_resp"}, {31'd0, rsp(1 - r)}, 32'd0);
      chk({tag, " resp_data"}, bus.resp_data, exp_d);
      chk({tag, " resp_err"}, {31'd0, bus.resp_err}, {31'd0, exp_e});
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      int grants;
      int exp_g;
      int n_resp;
      set_req(0, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);
      set_req(1, 1'b1, 4'd0, 32'd0, 32'd0, 5'd0);

      // Reset state: outputs 0 even with both requesters valid.
      @(negedge clk); @(negedge clk); #1;
      chk("rst ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("rst ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("rst busy", {31'd0, bus.busy}, 32'd0);
      chk("rst resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
      chk("rst resp_data", bus.resp_data, 32'd0);
      chk("rst alu_a", bus.alu_a, 32'd0);
      @(negedge clk);
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
      rst = 1'b0;

      // 1: single ADD.
      do_op("t1 add", 0, 4'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);

      // 2: contention right after reset -> req0 first, req1 four cycles later.
      pulse_reset();
      @(negedge clk);
      set_req(0, 1'b1, 4'd1, 32'd10, 32'd3, 5'd0);
      set_req(1, 1'b1, 4'd4, 32'hF0, 32'hFF, 5'd0);
      #1;
      chk("t2 ready0", {31'd0, bus.req0_ready}, 32'd1);
      chk("t2 ready1", {31'd0, bus.req1_ready}, 32'd0);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) bus.req0_valid = 1'b0;
         if (k == 5) bus.req1_valid = 1'b0;
         #1;
         if (k == 2) chk("t2 busy", {31'd0, bus.busy}, 32'd1);
         if (k == 3) begin
            chk("t2 resp0", {31'd0, bus.resp0_valid}, 32'd1);
            chk("t2 data0", bus.resp_data, 32'd7);
         end
         if (k == 4) begin
            chk("t2 ready1 late", {31'd0, bus.req1_ready}, 32'd1);
            chk("t2 resp0 pulse", {31'd0, bus.resp0_valid}, 32'd0);
            chk("t2 data hold", bus.resp_data, 32'd7);
         end
         if (k == 7) begin
            chk("t2 resp1", {31'd0, bus.resp1_valid}, 32'd1);
            chk("t2 data1", bus.resp_data, 32'h0F);
         end
      end

      // 3: both held valid for six ops -> 0,1,0,1,0,1.
      grants = 0; exp_g = 0; n_resp = 0;
      @(negedge clk);
      set_req(0, 1'b1, 4'd0, 32'd1, 32'd2, 5'd0);
      set_req(1, 1'b1, 4'd1, 32'd9, 32'd4, 5'd0);
      for (int c = 0; c < 28; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (grants == 6) begin
               bus.req0_valid = 1'b0;
               bus.req1_valid = 1'b0;
            end
         end
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
            chk("t3 one_ready", {30'd0, bus.req0_ready, bus.req1_ready} & 32'd3,
                exp_g == 0 ? 32'd2 : 32'd1);
            exp_g = 1 - exp_g;
            grants++;
         end
         if (bus.resp0_valid) begin chk("t3 data0", bus.resp_data, 32'd3); n_resp++; end
         if (bus.resp1_valid) begin chk("t3 data1", bus.resp_data, 32'd5); n_resp++; end
      end
      chk("t3 grants", grants, 32'd6);
      chk("t3 resps", n_resp, 32'd6);

      // 4: illegal funct, then a legal op on the same requester.
      do_op("t4 illegal", 1, 4'd12, 32'd33, 32'd44, 5'd0, 32'd0, 1'b1);
      do_op("t4 and", 1, 4'd2, 32'hFF, 32'h0F, 5'd0, 32'h0F, 1'b0);

      // 5: arithmetic shift right of a negative value.
      do_op("t5 sra", 0, 4'd7, 32'h8000_0000, 32'd1, 5'd0, 32'hC000_0000, 1'b0);

      // 6: reset during WAIT drops the op; grant pointer returns to req0 first.
      @(negedge clk);
      set_req(0, 1'b1, 4'd0, 32'd3, 32'd4, 5'd0);
      #1;
      chk("t6 ready", {31'd0, bus.req0_ready}, 32'd1);
      @(negedge clk);
      bus.req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      set_req(0, 1'b1, 4'd0, 32'd1, 32'd1, 5'd0);
      set_req(1, 1'b1, 4'd0, 32'd50, 32'd50, 5'd0);
      #1;
      chk("t6 rst ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("t6 rst ready1", {31'd0, bus.req1_ready}, 32'd0);
      chk("t6 rst busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t6 no resp", {30'd0, bus.resp0_valid, bus.resp1_valid}, 32'd0);
      chk("t6 ready0", {31'd0, bus.req0_ready}, 32'd1);
      chk("t6 ready1", {31'd0, bus.req1_ready}, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k == 1) begin
            set_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
            set_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
         end
         #1;
      end
      chk("t6 resp0", {31'd0, bus.resp0_valid}, 32'd1);
      chk("t6 data", bus.resp_data, 32'd2);
      chk("t6 err", {31'd0, bus.resp_err}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100000");
      $fatal(1, "watchdog expired");
   end

endmodule
